// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// FSM encodings, the NOP word loaded at reset and the sequential PC step.
package fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_HOLD  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FAULT = 3'd4
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] PC_STEP      = 32'd4;

   // Sequential successor; unsigned 32-bit add wraps FFFF_FFFC -> 0000_0000.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_ctrl_skid.sv
// fetch_skid: one-entry pc/instr holding buffer used when decode stalls
// while an instruction returns from memory. clear and unload win over load.
module fetch_skid
   import fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        unload,
   input  logic        clear,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;

   // Next-state for the buffer entry.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (clear || unload) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = pc_in;
         instr_d = instr_in;
      end
   end

   // Buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0;
         instr_q <= NOP_INSTR;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign instr = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, issues req/ack
// fetches, presents instructions to decode and handles redirects/draining.
// Handshake: a fetch is in progress while imem_req=1; imem_addr is held
// until the cycle imem_ack=1, which completes it (ack may come in the
// same cycle req rises). Decode consumes if_* whenever stall=0.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect
// target enters a sticky FAULT state with trap=1).
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         b_taken,
   input  logic [31:0]  b_pc,
   input  logic         stall,
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_ack,
   input  logic [31:0]  imem_rdata,
   output logic         if_valid,
   output logic [31:0]  if_pc,
   output logic [31:0]  if_instr,
   output logic         flush,
   output logic         trap,
   output fetch_state_e dbg_state
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  tgt_q, tgt_d;
   logic         if_valid_q, if_valid_d;
   logic [31:0]  if_pc_q, if_pc_d;
   logic [31:0]  if_instr_q, if_instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic         trap_q, trap_d;
   logic         fault_pend_q, fault_pend_d;
   logic         misalign;
`endif

   logic         skid_load, skid_unload, skid_clear;
   logic         skid_valid;
   logic [31:0]  skid_pc, skid_instr;
   logic         req_out;
   logic         outstanding;
   logic [31:0]  b_tgt;

   // Request is live in FETCH, and held through DRAIN until ack.
   assign req_out     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign outstanding = req_out && !imem_ack;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign b_tgt    = b_pc;
   assign misalign = (b_pc[1:0] != 2'b00);
`else
   // Low bits of the redirect target are ignored.
   assign b_tgt    = b_pc & ~32'h3;
`endif

   fetch_skid u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (skid_load),
      .unload   (skid_unload),
      .clear    (skid_clear),
      .pc_in    (pc_q),
      .instr_in (imem_rdata),
      .valid    (skid_valid),
      .pc       (skid_pc),
      .instr    (skid_instr)
   );

   // FSM, PC and output-register next-state; redirect overrides everything.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      tgt_d       = tgt_q;
      if_valid_d  = if_valid_q;
      if_pc_d     = if_pc_q;
      if_instr_d  = if_instr_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_d       = trap_q;
      fault_pend_d = fault_pend_q;
`endif

      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
            pc_d    = RESET_PC;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               pc_d = next_pc(pc_q);
               if (!if_valid_q || !stall) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = pc_q;
                  if_instr_d = imem_rdata;
               end else begin
                  skid_load = 1'b1;
                  state_d   = ST_HOLD;
               end
            end else if (!stall) begin
               if_valid_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (!stall) begin
               state_d = ST_FETCH;
               if (skid_valid) begin
                  if_valid_d  = 1'b1;
                  if_pc_d     = skid_pc;
                  if_instr_d  = skid_instr;
                  skid_unload = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            // Returned data belongs to the killed path and is dropped.
            if (imem_ack) begin
               state_d = ST_FETCH;
               pc_d    = tgt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
               if (fault_pend_q) begin
                  state_d = ST_FAULT;
                  trap_d  = 1'b1;
               end
`endif
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         ST_FAULT: begin
            if_valid_d = 1'b0;
         end
`endif
         default: begin
            state_d = ST_BOOT;
         end
      endcase

`ifdef FETCH_MISALIGN_TRAP_EN
      if (b_taken && (state_q != ST_FAULT)) begin
`else
      if (b_taken) begin
`endif
         if_valid_d  = 1'b0;
         skid_clear  = 1'b1;
         skid_load   = 1'b0;
         skid_unload = 1'b0;
         if (outstanding) begin
            // Keep pc_q (= imem_addr) stable; remember where to go after ack.
            state_d = ST_DRAIN;
            pc_d    = pc_q;
            tgt_d   = b_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_pend_d = misalign;
`endif
         end else begin
            state_d = ST_FETCH;
            pc_d    = b_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_pend_d = 1'b0;
            if (misalign) begin
               state_d = ST_FAULT;
               trap_d  = 1'b1;
            end
`endif
         end
      end
   end

   // State, PC and decode-facing output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         tgt_q      <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'h0;
         if_instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
         trap_q       <= 1'b0;
         fault_pend_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         tgt_q      <= tgt_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         trap_q       <= trap_d;
         fault_pend_q <= fault_pend_d;
`endif
      end
   end

   assign imem_req  = req_out;
   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_instr  = if_instr_q;
   assign flush     = b_taken;
   assign dbg_state = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign trap      = trap_q;
`else
   assign trap      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: sequential fetch, stall/skid,
// redirect with drain, redirect coincident with ack, PC wrap, misaligned
// redirect and reset during drain.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         b_taken;
   logic [31:0]  b_pc;
   logic         stall;
   logic         imem_req;
   logic [31:0]  imem_addr;
   logic         imem_ack;
   logic [31:0]  imem_rdata;
   logic         if_valid;
   logic [31:0]  if_pc;
   logic [31:0]  if_instr;
   logic         flush;
   logic         trap;
   fetch_state_e dbg_state;

   logic         auto_ack;
   logic         man_ack;
   int           checks;
   int           failures;

   // Instruction memory: word content is a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0000_0033;
   endfunction

   assign imem_ack   = auto_ack ? imem_req : man_ack;
   assign imem_rdata = mem_word(imem_addr);

   fetch_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .b_taken    (b_taken),
      .b_pc       (b_pc),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .flush      (flush),
      .trap       (trap),
      .dbg_state  (dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one cycle and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   {31'b0, imem_req}, 32'd0);
      chk({tag, "_addr"},  imem_addr, 32'h0);
      chk({tag, "_vld"},   {31'b0, if_valid}, 32'd0);
      chk({tag, "_pc"},    if_pc, 32'h0);
      chk({tag, "_instr"}, if_instr, 32'h0000_0013);
      chk({tag, "_trap"},  {31'b0, trap}, 32'd0);
      chk({tag, "_state"}, {29'b0, dbg_state}, {29'b0, ST_BOOT});
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      b_taken  = 1'b0;
      b_pc     = 32'h0;
      stall    = 1'b0;
      auto_ack = 1'b1;
      man_ack  = 1'b0;
      #2 rst_n = 1'b0;
      step();
      step();
      chk_reset_vals("rst");
      chk("rst_flush", {31'b0, flush}, 32'd0);

      // Sequential zero-wait fetch from RESET_PC
      rst_n = 1'b1;
      step();
      chk("seq_req0",  {31'b0, imem_req}, 32'd1);
      chk("seq_addr0", imem_addr, 32'h0);
      chk("seq_vld0",  {31'b0, if_valid}, 32'd0);
      step();
      chk("seq_addr4", imem_addr, 32'h4);
      chk("seq_vld1",  {31'b0, if_valid}, 32'd1);
      chk("seq_pc0",   if_pc, 32'h0);
      chk("seq_ins0",  if_instr, mem_word(32'h0));
      step();
      chk("seq_addr8", imem_addr, 32'h8);
      chk("seq_pc4",   if_pc, 32'h4);

      // Ack at 8 while stalled with valid output -> HOLD
      stall = 1'b1;
      step();
      chk("hold_req",   {31'b0, imem_req}, 32'd0);
      chk("hold_pc",    if_pc, 32'h4);
      chk("hold_state", {29'b0, dbg_state}, {29'b0, ST_HOLD});
      step();
      chk("hold_req2",  {31'b0, imem_req}, 32'd0);
      chk("hold_pc2",   if_pc, 32'h4);
      stall = 1'b0;
      step();
      chk("unhold_pc",  if_pc, 32'h8);
      chk("unhold_ins", if_instr, mem_word(32'h8));
      chk("unhold_req", {31'b0, imem_req}, 32'd1);
      chk("unhold_addr", imem_addr, 32'hC);
      step();
      chk("resume_pc",   if_pc, 32'hC);
      chk("resume_addr", imem_addr, 32'h10);

      // Request to 0x10 delayed; redirect to 0x100 drains it
      auto_ack = 1'b0;
      step();
      chk("wait_vld",  {31'b0, if_valid}, 32'd0);
      chk("wait_addr", imem_addr, 32'h10);
      b_taken = 1'b1;
      b_pc    = 32'h100;
      #1;
      chk("drn_flush", {31'b0, flush}, 32'd1);
      step();
      b_taken = 1'b0;
      #1;
      chk("drn_flush0", {31'b0, flush}, 32'd0);
      chk("drn_state",  {29'b0, dbg_state}, {29'b0, ST_DRAIN});
      chk("drn_req",    {31'b0, imem_req}, 32'd1);
      chk("drn_addr",   imem_addr, 32'h10);
      step();
      chk("drn_addr2",  imem_addr, 32'h10);
      chk("drn_vld",    {31'b0, if_valid}, 32'd0);
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      chk("drn_done_addr", imem_addr, 32'h100);
      chk("drn_done_vld",  {31'b0, if_valid}, 32'd0);
      chk("drn_done_req",  {31'b0, imem_req}, 32'd1);
      auto_ack = 1'b1;
      step();
      chk("tgt_pc",   if_pc, 32'h100);
      chk("tgt_vld",  {31'b0, if_valid}, 32'd1);
      chk("tgt_addr", imem_addr, 32'h104);

      // Redirect in the same cycle as ack: data for 0x104 discarded
      b_taken = 1'b1;
      b_pc    = 32'h200;
      step();
      b_taken = 1'b0;
      chk("ackbr_addr", imem_addr, 32'h200);
      chk("ackbr_vld",  {31'b0, if_valid}, 32'd0);
      step();
      chk("ackbr_pc",   if_pc, 32'h200);
      chk("ackbr_addr2", imem_addr, 32'h204);

      // Redirect overrides stall
      stall   = 1'b1;
      b_taken = 1'b1;
      b_pc    = 32'h300;
      step();
      b_taken = 1'b0;
      stall   = 1'b0;
      chk("brstall_addr", imem_addr, 32'h300);
      chk("brstall_vld",  {31'b0, if_valid}, 32'd0);

      // PC wrap
      b_taken = 1'b1;
      b_pc    = 32'hFFFF_FFFC;
      step();
      b_taken = 1'b0;
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr1", imem_addr, 32'h0);
      chk("wrap_pc",    if_pc, 32'hFFFF_FFFC);

      // Misaligned redirect target
      b_taken = 1'b1;
      b_pc    = 32'h102;
      step();
      b_taken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_trap",  {31'b0, trap}, 32'd1);
      chk("mis_req",   {31'b0, imem_req}, 32'd0);
      chk("mis_vld",   {31'b0, if_valid}, 32'd0);
      step();
      step();
      chk("mis_trap2", {31'b0, trap}, 32'd1);
      chk("mis_req2",  {31'b0, imem_req}, 32'd0);
`else
      chk("mis_addr",  imem_addr, 32'h100);
      chk("mis_trap",  {31'b0, trap}, 32'd0);
      step();
      chk("mis_pc",    if_pc, 32'h100);
      chk("mis_ins",   if_instr, mem_word(32'h100));
`endif
      rst_n = 1'b0;
      step();
      chk_reset_vals("rst2");
      rst_n = 1'b1;

      // Reset asserted while draining
      auto_ack = 1'b0;
      step();
      chk("rd_req",  {31'b0, imem_req}, 32'd1);
      b_taken = 1'b1;
      b_pc    = 32'h400;
      step();
      b_taken = 1'b0;
      chk("rd_state", {29'b0, dbg_state}, {29'b0, ST_DRAIN});
      chk("rd_addr",  imem_addr, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("rd_rst");
      step();
      rst_n    = 1'b1;
      auto_ack = 1'b1;
      step();
      chk("rd_restart_addr", imem_addr, 32'h0);
      chk("rd_restart_req",  {31'b0, imem_req}, 32'd1);
      step();
      chk("rd_restart_pc",   if_pc, 32'h0);
      chk("rd_restart_vld",  {31'b0, if_valid}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
